neopixel_receiver: RTL and testbench

NEOPIXEL_RECEIVER -- requirements
Module: neopixel_receiver

---
 rtl/neopix_pkg.sv | 18 +
 rtl/neopixel_receiver_synchronizer.sv | 25 ++
 rtl/neopixel_receiver.sv | 169 ++++++++++++++++
 tb/tb_neopixel_receiver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// Shared types and default timing for the WS2812 receiver.
// Holds FSM state encoding, cycle thresholds and word width.
package neopix_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_STUCK = 2'd3
  } state_t;

  localparam int THRESH_CYC   = 30;
  localparam int MIN_HIGH_CYC = 8;
  localparam int MAX_HIGH_CYC = 75;
  localparam int RESET_CYC    = 2500;
  localparam int PIXEL_BITS   = 24;

endpackage

// File: rtl/neopixel_receiver_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports: i_clk, i_rst_n (async low), i_d (async in), o_q (synced out).
module neopixel_receiver_synchronizer (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/neopixel_receiver.sv
// WS2812 line decoder: pixel words, frame latch detect, sticky error.
// Ports: CLOCK_50, reset_n (async low), neo_in, pixel_data/pixel_valid,
//   frame_done/frame_pixels, error, neo_out.
// Option: NEOPIX_RX_FORWARD_EN enables forwarding of pixels 2..N on neo_out.
module neopixel_receiver #(
  parameter int THRESH_CYC   = neopix_pkg::THRESH_CYC,
  parameter int MIN_HIGH_CYC = neopix_pkg::MIN_HIGH_CYC,
  parameter int MAX_HIGH_CYC = neopix_pkg::MAX_HIGH_CYC,
  parameter int RESET_CYC    = neopix_pkg::RESET_CYC
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        neo_in,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [9:0]  frame_pixels,
  output logic        error,
  output logic        neo_out
);

  import neopix_pkg::*;

  localparam int HW = $clog2(MAX_HIGH_CYC + 1);
  localparam int LW = $clog2(RESET_CYC + 1);

  localparam logic [HW-1:0] L_MIN   = HW'(MIN_HIGH_CYC);
  localparam logic [HW-1:0] L_THR   = HW'(THRESH_CYC);
  localparam logic [HW-1:0] L_MAXM1 = HW'(MAX_HIGH_CYC - 1);
  localparam logic [LW-1:0] L_RSTM1 = LW'(RESET_CYC - 1);
  localparam logic [4:0]    L_LAST  = 5'(PIXEL_BITS - 1);
  localparam logic [9:0]    L_PMAX  = 10'd1023;

  logic          w_sync;
  logic          r_prev;
  logic          w_rise;
  logic          w_fall;
  logic          w_bit;
  logic          w_px;
  logic          w_latch;
  state_t        r_state;
  logic [HW-1:0] r_hcnt;
  logic [LW-1:0] r_lcnt;
  logic [4:0]    r_bcnt;
  logic [9:0]    r_pcnt;
  logic [22:0]   r_shift;
  logic [23:0]   r_pix;
  logic          r_pvld;
  logic          r_fdone;
  logic [9:0]    r_fpix;
  logic          r_err;

  neopixel_receiver_synchronizer u_sync (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_d     (neo_in),
    .o_q     (w_sync)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_prev <= 1'b0;
    else          r_prev <= w_sync;
  end

  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;
  assign w_bit  = (r_hcnt >= L_THR);

  // 24th accepted bit completes a word
  assign w_px = (r_state == S_HIGH) && w_fall &&
                (r_hcnt >= L_MIN) && (r_bcnt == L_LAST);

  // RESET_CYC-th consecutive low cycle after a bit
  assign w_latch = (r_state == S_LOW) && !w_rise &&
                   (r_lcnt >= L_RSTM1);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
      r_bcnt  <= '0;
      r_pcnt  <= '0;
      r_shift <= '0;
      r_pix   <= '0;
      r_pvld  <= 1'b0;
      r_fdone <= 1'b0;
      r_fpix  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pvld  <= 1'b0;
      r_fdone <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_HIGH;
            r_hcnt  <= HW'(1);
          end
        end
        S_HIGH: begin
          if (w_fall) begin
            r_state <= S_LOW;
            r_lcnt  <= LW'(1);
            if (r_hcnt < L_MIN) begin
              r_err <= 1'b1;
            end else if (w_px) begin
              r_pix  <= {r_shift, w_bit};
              r_pvld <= 1'b1;
              r_bcnt <= '0;
              if (r_pcnt != L_PMAX) r_pcnt <= r_pcnt + 10'd1;
            end else begin
              r_shift <= {r_shift[21:0], w_bit};
              r_bcnt  <= r_bcnt + 5'd1;
            end
          end else if (r_hcnt >= L_MAXM1) begin
            r_err   <= 1'b1;
            r_bcnt  <= '0;
            r_state <= S_STUCK;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end
        S_LOW: begin
          if (w_rise) begin
            r_state <= S_HIGH;
            r_hcnt  <= HW'(1);
          end else if (w_latch) begin
            if (r_pcnt != 10'd0) begin
              r_fdone <= 1'b1;
              r_fpix  <= r_pcnt;
            end
            if (r_bcnt != 5'd0) r_err <= 1'b1;
            r_pcnt  <= '0;
            r_bcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_lcnt <= r_lcnt + LW'(1);
          end
        end
        S_STUCK: begin
          if (w_fall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pixel_data   = r_pix;
  assign pixel_valid  = r_pvld;
  assign frame_done   = r_fdone;
  assign frame_pixels = r_fpix;
  assign error        = r_err;

`ifdef NEOPIX_RX_FORWARD_EN
  // first pixel is consumed here; later pixels pass downstream
  logic r_fwd;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)     r_fwd <= 1'b0;
    else if (w_latch) r_fwd <= 1'b0;
    else if (w_px)    r_fwd <= 1'b1;
  end

  assign neo_out = w_sync & r_fwd;
`else
  assign neo_out = 1'b0;
`endif

endmodule

// File: tb/tb_neopixel_receiver.sv
// Scoreboard bench for neopixel_receiver: directed WS2812 waveforms.
// Stimulus queues expected pulses; a negedge monitor pops and compares.
module tb_neopixel_receiver;

`ifdef NEOPIX_RX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    bit          is_frame;
    logic [23:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        neo_in;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        frame_done;
  logic [9:0]  frame_pixels;
  logic        error;
  logic        neo_out;

  exp_t q[$];
  int   n_checks;
  int   n_errors;
  int   fwd_mode;

  neopixel_receiver dut (
    .CLOCK_50     (clk),
    .reset_n      (rst_n),
    .neo_in       (neo_in),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .error        (error),
    .neo_out      (neo_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pixel_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_pixel_valid", {8'd0, pixel_data}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind_pixel", {31'd0, e.is_frame}, 32'd0);
          chk("pixel_data", {8'd0, pixel_data}, {8'd0, e.val});
        end
      end
      if (frame_done) begin
        if (q.size() == 0) begin
          chk("unexpected_frame_done", {22'd0, frame_pixels}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind_frame", {31'd0, e.is_frame}, 32'd1);
          chk("frame_pixels", {22'd0, frame_pixels}, {22'd0, e.val[9:0]});
        end
      end
    end
  end

  task automatic send_bit(input bit b);
    int hi;
    int lo;
    hi = b ? 40 : 20;
    lo = b ? 22 : 42;
    neo_in = 1'b1;
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      if (i == 10 && fwd_mode != 0)
        chk("neo_out", {31'd0, neo_out},
            {31'd0, (fwd_mode == 2) && FWD});
    end
    neo_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    exp_t e;
    e.is_frame = 1'b0;
    e.val = p;
    q.push_back(e);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic latch(input int npix);
    exp_t e;
    if (npix > 0) begin
      e.is_frame = 1'b1;
      e.val = 24'(npix);
      q.push_back(e);
    end
    neo_in = 1'b0;
    repeat (2520) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    neo_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [23:0] part;
    n_checks = 0;
    n_errors = 0;
    fwd_mode = 0;
    rst_n = 1'b0;
    neo_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pixel_data", {8'd0, pixel_data}, 32'd0);
    chk("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frame_pixels", {22'd0, frame_pixels}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_neo_out", {31'd0, neo_out}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single pixel
    send_pixel(24'h808080);
    latch(1);
    chk("t1_queue_empty", q.size(), 32'd0);
    chk("t1_error", {31'd0, error}, 32'd0);

    // three pixels, GRB ordering preserved
    send_pixel(24'hFF0000);
    send_pixel(24'h00FF00);
    send_pixel(24'h0000FF);
    latch(3);
    chk("t2_queue_empty", q.size(), 32'd0);
    chk("t2_error", {31'd0, error}, 32'd0);

    // 5-cycle glitch mid-word must not be counted as a bit
    begin
      exp_t e;
      part = 24'hA5C3F0;
      e.is_frame = 1'b0;
      e.val = part;
      q.push_back(e);
      for (int i = 23; i >= 12; i--) send_bit(part[i]);
      neo_in = 1'b1;
      repeat (5) @(negedge clk);
      neo_in = 1'b0;
      repeat (40) @(negedge clk);
      chk("t3_error_after_glitch", {31'd0, error}, 32'd1);
      for (int i = 11; i >= 0; i--) send_bit(part[i]);
      latch(1);
    end
    chk("t3_queue_empty", q.size(), 32'd0);

    // partial word then latch: no pulses, error set
    do_reset();
    chk("t4_error_cleared", {31'd0, error}, 32'd0);
    part = 24'hABCDEF;
    for (int i = 23; i >= 12; i--) send_bit(part[i]);
    latch(0);
    chk("t4_queue_empty", q.size(), 32'd0);
    chk("t4_error", {31'd0, error}, 32'd1);

    // stuck-high line, then recovery
    do_reset();
    neo_in = 1'b1;
    repeat (100) @(negedge clk);
    chk("t5_error_stuck", {31'd0, error}, 32'd1);
    neo_in = 1'b0;
    repeat (50) @(negedge clk);
    send_pixel(24'h123456);
    latch(1);
    chk("t5_queue_empty", q.size(), 32'd0);

    // reset mid-pixel discards the partial word
    do_reset();
    part = 24'h5A5A5A;
    for (int i = 23; i >= 14; i--) send_bit(part[i]);
    neo_in = 1'b1;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    neo_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_pixel_data", {8'd0, pixel_data}, 32'd0);
    chk("t6_rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    chk("t6_rst_frame_pixels", {22'd0, frame_pixels}, 32'd0);
    chk("t6_rst_error", {31'd0, error}, 32'd0);
    chk("t6_rst_neo_out", {31'd0, neo_out}, 32'd0);
    rst_n = 1'b1;
    repeat (3000) @(negedge clk);
    chk("t6_no_pulse", q.size(), 32'd0);
    fwd_mode = 1;
    send_pixel(24'h0F0F0F);
    fwd_mode = 2;
    send_pixel(24'hF0F0F0);
    fwd_mode = 0;
    latch(2);
    chk("t6_queue_empty", q.size(), 32'd0);
    chk("t6_error", {31'd0, error}, 32'd0);
    chk("t6_neo_out_after_latch", {31'd0, neo_out}, 32'd0);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
